ucsbece154a_uart_tx: RTL

UCSBECE154A_UART_TX -- requirements
Module: ucsbece154a_uart_tx

---
 rtl/ucsbece154a_uart_tx.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ucsbece154a_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS register window, circular byte FIFO
// and an 8N1 serializer with a level interrupt for "drained" or "overflowed".
module ucsbece154a_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [31:0] a_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_o,
    output logic        sel_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [NW-1:0] FULL_CNT  = NW'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [NW-1:0]   count_r;
    logic [7:0]      mem_r [DEPTH];
    logic [BW-1:0]   baud_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic            tx_r;
    logic            irq_r;
    logic            ovf_r;

    logic            sel_s;
    logic            full_s;
    logic            empty_s;
    logic            busy_s;
    logic            push_req_s;
    logic            push_s;
    logic            drop_s;
    logic            clr_s;
    logic            pop_s;
    logic            baud_last_s;
    logic [7:0]      head_s;
    logic [3:0]      status_cnt_s;
    logic [31:0]     rd_s;
    logic            unused_s;

    assign sel_s        = (a_i[31:3] == BASE_ADDR[31:3]);
    assign full_s       = (count_r == FULL_CNT);
    assign empty_s      = (count_r == {NW{1'b0}});
    assign busy_s       = (state_r != IDLE);
    assign baud_last_s  = (baud_r == BAUD_LAST);
    assign head_s       = mem_r[rd_ptr_r];
    assign status_cnt_s = 4'(count_r);

    // A store into a full FIFO is dropped and flags overflow; full is the pre-edge value.
    assign push_req_s = we_i & sel_s & ~a_i[2];
    assign push_s     = push_req_s & ~full_s;
    assign drop_s     = push_req_s & full_s;
    assign clr_s      = we_i & sel_s & a_i[2] & wd_i[3];

    assign unused_s = ^{a_i[1:0], wd_i[31:8]};

    // Pop when the serializer is ready for a new byte: from IDLE, or at STOP expiry.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE:    pop_s = ~empty_s;
            STOP:    pop_s = baud_last_s & ~empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Register read mux; the window reads as zero when not selected.
    always_comb begin
        rd_s = 32'd0;
        if (sel_s && a_i[2]) begin
            rd_s = {24'd0, status_cnt_s, ovf_r, busy_s, empty_s, full_s};
        end else begin
            rd_s = 32'd0;
        end
    end

    // FIFO data storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wd_i[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag (set beats clear).
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {NW{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + NW'(1);
                2'b01:   count_r <= count_r - NW'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (clr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Serializer FSM; tx_r is loaded with the level of the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            baud_r    <= {BW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    baud_r    <= {BW{1'b0}};
                    bit_idx_r <= 3'd0;
                    if (!empty_s) begin
                        shift_r <= head_s;
                        state_r <= START;
                        tx_r    <= 1'b0;
                    end else begin
                        tx_r    <= 1'b1;
                    end
                end
                START: begin
                    if (baud_last_s) begin
                        baud_r    <= {BW{1'b0}};
                        bit_idx_r <= 3'd0;
                        state_r   <= DATA;
                        tx_r      <= shift_r[0];
                    end else begin
                        baud_r    <= baud_r + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last_s) begin
                        baud_r <= {BW{1'b0}};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_last_s) begin
                        baud_r    <= {BW{1'b0}};
                        bit_idx_r <= 3'd0;
                        if (!empty_s) begin
                            shift_r <= head_s;
                            state_r <= START;
                            tx_r    <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            tx_r    <= 1'b1;
                        end
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    baud_r    <= {BW{1'b0}};
                    bit_idx_r <= 3'd0;
                    tx_r      <= 1'b1;
                end
            endcase
        end
    end

    // Level interrupt: transmitter fully drained, or a byte was lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= (empty_s & ~busy_s) | ovf_r;
        end
    end

    assign rd_o  = rd_s;
    assign sel_o = sel_s;
    assign tx_o  = tx_r;
    assign irq_o = irq_r;

endmodule
